// File: rtl/alu_ctrl_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct constants and the decoded control bundle.
// Used by the ALU control stage, its decoder and the ALU itself.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SRL = 5'b10000;
  localparam logic [4:0] ALU_SRA = 5'b11000;
  localparam logic [4:0] ALU_SLL = 5'b11001;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [4:0] aluconf;
    logic       sign;
    logic       src1_shamt;
    logic       src2_imm;
    logic       illegal;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_NONE    = '0;
  localparam alu_ctrl_t CTRL_ILLEGAL = '{aluconf: ALU_ADD, sign: 1'b0, src1_shamt: 1'b0,
                                         src2_imm: 1'b0, illegal: 1'b1};

  function automatic alu_ctrl_t mk_ctrl(input logic [4:0] conf, input logic sign,
                                        input logic shamt, input logic imm);
    return '{aluconf: conf, sign: sign, src1_shamt: shamt, src2_imm: imm, illegal: 1'b0};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Purely combinational MIPS opcode/funct -> ALU control decode table.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output alu_ctrl_t   ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    ctrl = CTRL_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_JR: ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0);
          FN_SUB, FN_SUBU:        ctrl = mk_ctrl(ALU_SUB, 1'b1, 1'b0, 1'b0);
          FN_AND:                 ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0);
          FN_OR:                  ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b0, 1'b0);
          FN_XOR:                 ctrl = mk_ctrl(ALU_XOR, 1'b0, 1'b0, 1'b0);
          FN_NOR:                 ctrl = mk_ctrl(ALU_NOR, 1'b0, 1'b0, 1'b0);
          FN_SLT:                 ctrl = mk_ctrl(ALU_SLT, 1'b1, 1'b0, 1'b0);
          FN_SLTU:                ctrl = mk_ctrl(ALU_SLT, 1'b0, 1'b0, 1'b0);
          FN_SLL:                 ctrl = mk_ctrl(ALU_SLL, 1'b0, 1'b1, 1'b0);
          FN_SRL:                 ctrl = mk_ctrl(ALU_SRL, 1'b0, 1'b1, 1'b0);
          FN_SRA:                 ctrl = mk_ctrl(ALU_SRA, 1'b0, 1'b1, 1'b0);
          default:                ctrl = CTRL_ILLEGAL;
        endcase
      end
      // Loads, stores and lui all compute an address/sum with the immediate
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_LUI:
                 ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1);
      OP_ANDI:   ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b1);
      OP_ORI:    ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b0, 1'b1);
      OP_XORI:   ctrl = mk_ctrl(ALU_XOR, 1'b0, 1'b0, 1'b1);
      OP_SLTI:   ctrl = mk_ctrl(ALU_SLT, 1'b1, 1'b0, 1'b1);
      OP_SLTIU:  ctrl = mk_ctrl(ALU_SLT, 1'b0, 1'b0, 1'b1);
      OP_BEQ, OP_BNE:
                 ctrl = mk_ctrl(ALU_SUB, 1'b1, 1'b0, 1'b0);
      default:   ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control pipeline stage: decodes ID instructions into registered EX controls.
// Define ALU_CTRL_SKID_EN to place a SKID_DEPTH-entry FIFO ahead of the output register.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int SKID_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_aluconf,
  output logic        out_sign,
  output logic        out_src1_shamt,
  output logic        out_src2_imm,
  output logic        out_illegal
);

  if (SKID_DEPTH < 1) begin : g_bad_depth
    $error("SKID_DEPTH must be at least 1");
  end

  alu_ctrl_t dec_ctrl;
  alu_ctrl_t out_ctrl_reg;
  logic      out_valid_reg;
  logic      out_load;
  logic      accept;

  alu_ctrl_dec u_dec (
    .instr (in_instr),
    .ctrl  (dec_ctrl)
  );

  assign out_load = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ALU_CTRL_SKID_EN
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  alu_ctrl_t        fifo_mem [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             not_full_reg;
  logic             pop;
  logic             bypass;
  logic             push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // An empty FIFO lets a fresh decode go straight to the output register
  assign pop      = out_load && (count_reg != '0);
  assign bypass   = accept && out_load && (count_reg == '0);
  assign push     = accept && !bypass;
  assign in_ready = not_full_reg;

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr_reg] <= dec_ctrl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      not_full_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_ctrl_reg  <= CTRL_NONE;
    end else begin
      count_reg    <= count_next;
      not_full_reg <= (int'(count_next) < SKID_DEPTH);
      if (flush) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop) begin
          rd_ptr_reg    <= ptr_inc(rd_ptr_reg);
          out_ctrl_reg  <= fifo_mem[rd_ptr_reg];
          out_valid_reg <= 1'b1;
        end else if (bypass) begin
          out_ctrl_reg  <= dec_ctrl;
          out_valid_reg <= 1'b1;
        end else if (out_load) begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end
`else
  // Held low through reset so in_ready only rises on the first edge after release
  logic alive_reg;

  assign in_ready = alive_reg && out_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      out_ctrl_reg  <= CTRL_NONE;
    end else begin
      alive_reg <= 1'b1;
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (out_load) begin
        out_valid_reg <= accept;
        if (accept) out_ctrl_reg <= dec_ctrl;
      end
    end
  end
`endif

  assign out_valid      = out_valid_reg;
  assign out_aluconf    = out_ctrl_reg.aluconf;
  assign out_sign       = out_ctrl_reg.sign;
  assign out_src1_shamt = out_ctrl_reg.src1_shamt;
  assign out_src2_imm   = out_ctrl_reg.src2_imm;
  assign out_illegal    = out_ctrl_reg.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: expected controls are queued on accept, checked on transfer.
module tb_alu_ctrl_stage;

  localparam int NT = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_aluconf;
  logic        out_sign;
  logic        out_src1_shamt;
  logic        out_src2_imm;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] tbl_instr [NT];
  logic [8:0]  tbl_exp   [NT];   // {aluconf, sign, src1_shamt, src2_imm, illegal}
  logic [8:0]  sb [$];
  logic        hold_chk    = 1'b0;
  logic [9:0]  held        = '0;
  logic        expect_out  = 1'b0;
  logic        last_accept = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.SKID_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_aluconf    (out_aluconf),
    .out_sign       (out_sign),
    .out_src1_shamt (out_src1_shamt),
    .out_src2_imm   (out_src2_imm),
    .out_illegal    (out_illegal)
  );

  task automatic init_table();
    tbl_instr[0]  = 32'h012A4020; tbl_exp[0]  = {5'b00000, 4'b1000}; // add
    tbl_instr[1]  = 32'h00094100; tbl_exp[1]  = {5'b11001, 4'b0100}; // sll
    tbl_instr[2]  = 32'h2D2A0001; tbl_exp[2]  = {5'b00111, 4'b0010}; // sltiu
    tbl_instr[3]  = 32'hFC000000; tbl_exp[3]  = {5'b00000, 4'b0001}; // bad opcode
    tbl_instr[4]  = 32'h012A4022; tbl_exp[4]  = {5'b00110, 4'b1000}; // sub
    tbl_instr[5]  = 32'h012A4024; tbl_exp[5]  = {5'b00010, 4'b0000}; // and
    tbl_instr[6]  = 32'h012A4025; tbl_exp[6]  = {5'b00001, 4'b0000}; // or
    tbl_instr[7]  = 32'h012A4026; tbl_exp[7]  = {5'b01101, 4'b0000}; // xor
    tbl_instr[8]  = 32'h012A4027; tbl_exp[8]  = {5'b01100, 4'b0000}; // nor
    tbl_instr[9]  = 32'h012A402A; tbl_exp[9]  = {5'b00111, 4'b1000}; // slt
    tbl_instr[10] = 32'h012A402B; tbl_exp[10] = {5'b00111, 4'b0000}; // sltu
    tbl_instr[11] = 32'h00094102; tbl_exp[11] = {5'b10000, 4'b0100}; // srl
    tbl_instr[12] = 32'h00094103; tbl_exp[12] = {5'b11000, 4'b0100}; // sra
    tbl_instr[13] = 32'h01200008; tbl_exp[13] = {5'b00000, 4'b1000}; // jr
    tbl_instr[14] = 32'h21280005; tbl_exp[14] = {5'b00000, 4'b1010}; // addi
    tbl_instr[15] = 32'h35280005; tbl_exp[15] = {5'b00001, 4'b0010}; // ori
    tbl_instr[16] = 32'h31280005; tbl_exp[16] = {5'b00010, 4'b0010}; // andi
    tbl_instr[17] = 32'h8D280004; tbl_exp[17] = {5'b00000, 4'b1010}; // lw
    tbl_instr[18] = 32'h112A0003; tbl_exp[18] = {5'b00110, 4'b1000}; // beq
    tbl_instr[19] = 32'h2928FFFF; tbl_exp[19] = {5'b00111, 4'b1010}; // slti
    tbl_instr[20] = 32'h0000003F; tbl_exp[20] = {5'b00000, 4'b0001}; // bad funct
    tbl_instr[21] = 32'h3C081234; tbl_exp[21] = {5'b00000, 4'b1010}; // lui
    tbl_instr[22] = 32'h39280005; tbl_exp[22] = {5'b01101, 4'b0010}; // xori
    tbl_instr[23] = 32'h152A0003; tbl_exp[23] = {5'b00110, 4'b1000}; // bne
  endtask

  // One clock of stimulus plus all per-cycle checks; inputs change and outputs are sampled at negedge
  task automatic cycle(input logic v, input int k, input logic r, input logic f);
    logic [8:0] got;
    logic [8:0] exp;
    logic       acc;
    @(negedge clk);
    in_valid  = v;
    in_instr  = tbl_instr[k];
    out_ready = r;
    flush     = f;
    #1;
    got = {out_aluconf, out_sign, out_src1_shamt, out_src2_imm, out_illegal};
    if (expect_out) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL latency out_valid got %b exp 1", out_valid);
      end
    end
    if (hold_chk) begin
      checks++;
      if ({out_valid, got} !== held) begin
        errors++;
        $display("FAIL stall_hold got %h exp %h", {out_valid, got}, held);
      end
    end
`ifndef ALU_CTRL_SKID_EN
    checks++;
    if (in_ready !== (!out_valid || r)) begin
      errors++;
      $display("FAIL in_ready got %b exp %b", in_ready, (!out_valid || r));
    end
`endif
    if (out_valid === 1'b1 && r) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h exp none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL decode got %h exp %h", got, exp);
        end
      end
    end
    acc        = v && (in_ready === 1'b1);
    hold_chk   = (out_valid === 1'b1) && !r && !f;
    held       = {1'b1, got};
    expect_out = acc && !f && (sb.size() == 0);
    if (f) sb.delete();
    else if (acc) sb.push_back(tbl_exp[k]);
    last_accept = acc;
    $display("cyc v=%b instr=%h rdy=%b fl=%b acc=%b out_v=%b out=%h pend=%0d",
             v, tbl_instr[k], r, f, acc, out_valid, got, sb.size());
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", sb.size());
    end
    cycle(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, out_aluconf, out_sign, out_src1_shamt, out_src2_imm, out_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b exp 0", {out_valid, in_ready, out_aluconf, out_sign,
               out_src1_shamt, out_src2_imm, out_illegal});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b exp 0", in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got %b exp 1", in_ready);
    end
  endtask

  task automatic test_add();
    cycle(1'b1, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1, 1'b1, 1'b0);
    cycle(1'b1, 2, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_stall();
    int idx = 5;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, idx, (c >= 4), 1'b0);
      if (last_accept) idx = (idx + 1) % NT;
    end
    drain();
  endtask

  task automatic test_illegal();
    cycle(1'b1, 3, 1'b1, 1'b0);
    cycle(1'b1, 20, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_flush();
    cycle(1'b1, 0, 1'b1, 1'b0);
    cycle(1'b1, 4, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept out_valid got %b exp 0", out_valid);
    end
    cycle(1'b1, 5, 1'b0, 1'b0);
    cycle(1'b1, 6, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_held out_valid got %b exp 0", out_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 7, 1'b0, 1'b0);
    cycle(1'b1, 8, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_aluconf} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {out_valid, in_ready, out_aluconf});
    end
    sb.delete();
    hold_chk = 1'b0; expect_out = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 4, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_random();
    int  idx = 0;
    logic v, r, f;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 99) < 75);
      r = ($urandom_range(0, 99) < 60);
      f = ($urandom_range(0, 99) < 4);
      cycle(v, idx, r, f);
      if (last_accept) idx = $urandom_range(0, NT - 1);
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    init_table();
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
